// File: rtl/instr_mem_arbiter.sv
// Two-port instruction-fetch arbiter: shares one memory port and routes in-order responses via an ID FIFO.
// Optional macro IMEM_ARB_FIXED_PRIO_EN selects fixed core-0 priority instead of round-robin.
module instr_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        c0_req_i,
    output logic        c0_gnt_o,
    input  logic [31:0] c0_addr_i,
    output logic        c0_rvalid_o,
    output logic [31:0] c0_rdata_o,
    output logic        c0_err_o,

    input  logic        c1_req_i,
    output logic        c1_gnt_o,
    input  logic [31:0] c1_addr_i,
    output logic        c1_rvalid_o,
    output logic [31:0] c1_rdata_o,
    output logic        c1_err_o,

    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,

    output logic        proto_err_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [MAX_OUTSTANDING-1:0] id_mem_q, id_mem_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       proto_err_q, proto_err_d;

    logic req_any;
    logic full;
    logic empty;
    logic winner;
    logic handshake;
    logic pop;
    logic head_id;

`ifndef IMEM_ARB_FIXED_PRIO_EN
    logic rr_q, rr_d;
    logic both_req;
`endif

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (MAX_OUTSTANDING == 1) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Request path; everything is gated by rst_ni so outputs drop immediately on reset.
    always_comb begin
        req_any = c0_req_i | c1_req_i;
        full    = (count_q == CNT_W'(MAX_OUTSTANDING));
`ifdef IMEM_ARB_FIXED_PRIO_EN
        winner  = c1_req_i & ~c0_req_i;
`else
        both_req = c0_req_i & c1_req_i;
        winner   = both_req ? rr_q : c1_req_i;
`endif
        instr_req_o  = rst_ni & req_any & ~full;
        instr_addr_o = '0;
        if (rst_ni && req_any) begin
            instr_addr_o = winner ? c1_addr_i : c0_addr_i;
        end
        handshake = instr_req_o & instr_gnt_i;
        c0_gnt_o  = handshake & ~winner;
        c1_gnt_o  = handshake & winner;
    end

    // Response path: the FIFO head names the core that issued the oldest outstanding fetch.
    always_comb begin
        empty   = (count_q == '0);
        pop     = rst_ni & instr_rvalid_i & ~empty;
        head_id = id_mem_q[rd_ptr_q];

        c0_rvalid_o = pop & ~head_id;
        c1_rvalid_o = pop & head_id;
        c0_rdata_o  = '0;
        c1_rdata_o  = '0;
        c0_err_o    = 1'b0;
        c1_err_o    = 1'b0;
        if (pop && !head_id) begin
            c0_rdata_o = instr_rdata_i;
            c0_err_o   = instr_err_i;
        end
        if (pop && head_id) begin
            c1_rdata_o = instr_rdata_i;
            c1_err_o   = instr_err_i;
        end
        proto_err_o = proto_err_q;
    end

    always_comb begin
        id_mem_d    = id_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q | (instr_rvalid_i & empty);

        if (handshake) begin
            id_mem_d[wr_ptr_q] = winner;
            wr_ptr_d           = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        // A push and a pop in the same cycle leave the occupancy unchanged.
        case ({handshake, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifndef IMEM_ARB_FIXED_PRIO_EN
    // The pointer only moves on contention so a lone requester never disturbs fairness.
    always_comb begin
        rr_d = rr_q;
        if (handshake && both_req) begin
            rr_d = ~winner;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_mem_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            id_mem_q    <= id_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifndef IMEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Self-checking bench for instr_mem_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_instr_mem_arbiter;

    localparam int MAXO = 2;
`ifdef IMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst_ni;
    logic        c0_req_i, c1_req_i;
    logic [31:0] c0_addr_i, c1_addr_i;
    logic        c0_gnt_o, c1_gnt_o;
    logic        c0_rvalid_o, c1_rvalid_o;
    logic [31:0] c0_rdata_o, c1_rdata_o;
    logic        c0_err_o, c1_err_o;
    logic        instr_req_o, instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        proto_err_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state: issuer IDs in grant order, contention preference, sticky error.
    int          idq[$];
    bit          m_pref;
    bit          m_perr;
    logic        e_req, e_g0, e_g1, e_win, e_pop;
    logic        e_rv0, e_rv1, e_err0, e_err1;
    logic [31:0] e_addr, e_rd0, e_rd1;

    instr_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .c0_req_i       (c0_req_i),
        .c0_gnt_o       (c0_gnt_o),
        .c0_addr_i      (c0_addr_i),
        .c0_rvalid_o    (c0_rvalid_o),
        .c0_rdata_o     (c0_rdata_o),
        .c0_err_o       (c0_err_o),
        .c1_req_i       (c1_req_i),
        .c1_gnt_o       (c1_gnt_o),
        .c1_addr_i      (c1_addr_i),
        .c1_rvalid_o    (c1_rvalid_o),
        .c1_rdata_o     (c1_rdata_o),
        .c1_err_o       (c1_err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .proto_err_o    (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        c0_req_i       = 1'b0;
        c1_req_i       = 1'b0;
        c0_addr_i      = '0;
        c1_addr_i      = '0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic model_reset();
        idq.delete();
        m_pref = 1'b0;
        m_perr = 1'b0;
    endtask

    // Expected combinational outputs from the arbitration and routing rules.
    task automatic model_eval();
        logic any;
        any = c0_req_i | c1_req_i;
        if (c0_req_i && c1_req_i) e_win = FIXED ? 1'b0 : m_pref;
        else                      e_win = c1_req_i;
        e_req  = rst_ni && any && (idq.size() < MAXO);
        e_addr = (rst_ni && any) ? (e_win ? c1_addr_i : c0_addr_i) : 32'h0;
        e_g0   = e_req && instr_gnt_i && !e_win;
        e_g1   = e_req && instr_gnt_i && e_win;
        e_pop  = rst_ni && instr_rvalid_i && (idq.size() > 0);
        e_rv0  = e_pop && (idq[0] == 0);
        e_rv1  = e_pop && (idq[0] == 1);
        e_rd0  = e_rv0 ? instr_rdata_i : 32'h0;
        e_rd1  = e_rv1 ? instr_rdata_i : 32'h0;
        e_err0 = e_rv0 && instr_err_i;
        e_err1 = e_rv1 && instr_err_i;
    endtask

    task automatic model_commit();
        if (e_pop) void'(idq.pop_front());
        else if (instr_rvalid_i) m_perr = 1'b1;
        if (e_g0 || e_g1) begin
            idq.push_back(e_win ? 1 : 0);
            if (c0_req_i && c1_req_i && !FIXED) m_pref = !e_win;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b1;
        clear_inputs();
        #2;
        rst_ni         = 1'b0;
        c0_req_i       = 1'b1;
        c1_req_i       = 1'b1;
        c0_addr_i      = 32'h1234;
        instr_gnt_i    = 1'b1;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({instr_req_o, c0_gnt_o, c1_gnt_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_req_gnt: got %b required 000", {instr_req_o, c0_gnt_o, c1_gnt_o});
        end
        checks++;
        if ({c0_rvalid_o, c1_rvalid_o, c0_err_o, c1_err_o, proto_err_o} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_rvalid_err: got %b required 00000",
                     {c0_rvalid_o, c1_rvalid_o, c0_err_o, c1_err_o, proto_err_o});
        end
        checks++;
        if ({instr_addr_o, c0_rdata_o, c1_rdata_o} !== 96'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: got addr=%h rd0=%h rd1=%h required all 0",
                     instr_addr_o, c0_rdata_o, c1_rdata_o);
        end
        do_reset();
    endtask

    task automatic test_single_core();
        do_reset();
        @(negedge clk);
        c0_req_i    = 1'b1;
        c0_addr_i   = 32'h100;
        instr_gnt_i = 1'b1;
        #1;
        checks++;
        if ({instr_req_o, c0_gnt_o, c1_gnt_o} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL single_gnt: got req/g0/g1=%b required 110", {instr_req_o, c0_gnt_o, c1_gnt_o});
        end
        checks++;
        if (instr_addr_o !== 32'h100) begin
            failures++;
            $display("[TB] FAIL single_addr: got %h required 00000100", instr_addr_o);
        end
        @(negedge clk);
        c0_req_i       = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hDEADBEEF;
        #1;
        checks++;
        if ({c0_rvalid_o, c1_rvalid_o, c0_err_o} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL single_rvalid: got rv0/rv1/err0=%b required 100", {c0_rvalid_o, c1_rvalid_o, c0_err_o});
        end
        checks++;
        if (c0_rdata_o !== 32'hDEADBEEF || c1_rdata_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL single_rdata: got rd0=%h rd1=%h required deadbeef/0", c0_rdata_o, c1_rdata_o);
        end
        @(negedge clk);
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_w, prev_w;
        do_reset();
        prev_w = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c0_req_i       = 1'b1;
            c1_req_i       = 1'b1;
            c0_addr_i      = 32'h200;
            c1_addr_i      = 32'h300;
            instr_gnt_i    = 1'b1;
            instr_rvalid_i = (i > 0);
            instr_rdata_i  = 32'hA000 + i;
            exp_w = FIXED ? 1'b0 : ((i % 2) == 1);
            #1;
            checks++;
            if ({c0_gnt_o, c1_gnt_o} !== {!exp_w, exp_w}) begin
                failures++;
                $display("[TB] FAIL rr_gnt[%0d]: got g0/g1=%b%b required %b%b", i, c0_gnt_o, c1_gnt_o, !exp_w, exp_w);
            end
            checks++;
            if (instr_addr_o !== (exp_w ? 32'h300 : 32'h200)) begin
                failures++;
                $display("[TB] FAIL rr_addr[%0d]: got %h required %h", i, instr_addr_o, exp_w ? 32'h300 : 32'h200);
            end
            if (i > 0) begin
                checks++;
                if ({c0_rvalid_o, c1_rvalid_o} !== {!prev_w, prev_w}) begin
                    failures++;
                    $display("[TB] FAIL rr_route[%0d]: got rv0/rv1=%b%b required %b%b",
                             i, c0_rvalid_o, c1_rvalid_o, !prev_w, prev_w);
                end
            end
            prev_w = exp_w;
        end
        @(negedge clk);
        clear_inputs();
        instr_rvalid_i = 1'b1;
        @(negedge clk);
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        @(negedge clk);
        c0_req_i = 1'b1; c0_addr_i = 32'h10; instr_gnt_i = 1'b1;
        #1;
        checks++;
        if (c0_gnt_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_g0_first: got %b required 1", c0_gnt_o);
        end
        @(negedge clk);
        c0_req_i = 1'b0; c1_req_i = 1'b1; c1_addr_i = 32'h20;
        #1;
        checks++;
        if (c1_gnt_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_g1_second: got %b required 1", c1_gnt_o);
        end
        @(negedge clk);
        c0_req_i = 1'b1; c0_addr_i = 32'h30; c1_req_i = 1'b0;
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h11;
        #1;
        checks++;
        if ({instr_req_o, c0_gnt_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL full_blocked: got req/g0=%b required 00", {instr_req_o, c0_gnt_o});
        end
        checks++;
        if ({c0_rvalid_o, c1_rvalid_o} !== 2'b10 || c0_rdata_o !== 32'h11) begin
            failures++;
            $display("[TB] FAIL full_resp0: got rv=%b%b rd0=%h required 10/00000011", c0_rvalid_o, c1_rvalid_o, c0_rdata_o);
        end
        @(negedge clk);
        instr_rdata_i = 32'h22; instr_err_i = 1'b1;
        #1;
        checks++;
        if ({instr_req_o, c0_gnt_o} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL full_reopen: got req/g0=%b required 11", {instr_req_o, c0_gnt_o});
        end
        checks++;
        if ({c0_rvalid_o, c1_rvalid_o, c1_err_o} !== 3'b011 || c1_rdata_o !== 32'h22) begin
            failures++;
            $display("[TB] FAIL full_resp1: got rv0/rv1/err1=%b%b%b rd1=%h required 011/00000022",
                     c0_rvalid_o, c1_rvalid_o, c1_err_o, c1_rdata_o);
        end
        @(negedge clk);
        c0_req_i = 1'b0; instr_gnt_i = 1'b0; instr_err_i = 1'b0; instr_rdata_i = 32'h33;
        #1;
        checks++;
        if ({c0_rvalid_o, c1_rvalid_o, proto_err_o} !== 3'b100 || c0_rdata_o !== 32'h33) begin
            failures++;
            $display("[TB] FAIL full_resp2: got rv0/rv1/perr=%b%b%b rd0=%h required 100/00000033",
                     c0_rvalid_o, c1_rvalid_o, proto_err_o, c0_rdata_o);
        end
        @(negedge clk);
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_proto_err();
        do_reset();
        @(negedge clk);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h55;
        #1;
        checks++;
        if ({c0_rvalid_o, c1_rvalid_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL perr_drop: got rv0/rv1=%b%b required 00", c0_rvalid_o, c1_rvalid_o);
        end
        @(negedge clk);
        instr_rvalid_i = 1'b0;
        #1;
        checks++;
        if (proto_err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL perr_set: got %b required 1", proto_err_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (proto_err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL perr_sticky: got %b required 1", proto_err_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (proto_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL perr_clear: got %b required 0", proto_err_o);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        c0_req_i = 1'b1; c0_addr_i = 32'h40; instr_gnt_i = 1'b1;
        @(negedge clk);
        c0_req_i = 1'b0; c1_req_i = 1'b1; c1_addr_i = 32'h50;
        @(negedge clk);
        c0_req_i = 1'b1; c1_req_i = 1'b1; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h66;
        #1;
        checks++;
        if (c0_rvalid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_pre_rvalid: got %b required 1", c0_rvalid_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({instr_req_o, c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL mid_async: got req/g0/g1/rv0/rv1=%b required 00000",
                     {instr_req_o, c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o});
        end
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h77;
        #1;
        checks++;
        if ({c0_rvalid_o, c1_rvalid_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mid_stale_drop: got rv0/rv1=%b%b required 00", c0_rvalid_o, c1_rvalid_o);
        end
        @(negedge clk);
        instr_rvalid_i = 1'b0;
        #1;
        checks++;
        if (proto_err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_perr: got %b required 1", proto_err_o);
        end
    endtask

    task automatic test_random();
        bit p0, p1;
        logic [7:0] ctrl, exp_ctrl;
        do_reset();
        model_reset();
        p0 = 1'b0;
        p1 = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!p0) begin
                p0 = ($urandom_range(0, 2) != 0);
                c0_addr_i = $urandom;
            end
            if (!p1) begin
                p1 = ($urandom_range(0, 2) != 0);
                c1_addr_i = $urandom;
            end
            c0_req_i       = p0;
            c1_req_i       = p1;
            instr_gnt_i    = ($urandom_range(0, 9) < 7);
            instr_rvalid_i = (idq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            instr_rdata_i  = $urandom;
            instr_err_i    = ($urandom_range(0, 7) == 0);
            #1;
            model_eval();
            ctrl     = {instr_req_o, c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o, c0_err_o, c1_err_o, proto_err_o};
            exp_ctrl = {e_req, e_g0, e_g1, e_rv0, e_rv1, e_err0, e_err1, m_perr};
            checks++;
            if (ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL rand_ctrl[%0d]: got req/g0/g1/rv0/rv1/e0/e1/perr=%b required %b", cyc, ctrl, exp_ctrl);
            end
            checks++;
            if (instr_addr_o !== e_addr) begin
                failures++;
                $display("[TB] FAIL rand_addr[%0d]: got %h required %h", cyc, instr_addr_o, e_addr);
            end
            checks++;
            if (c0_rdata_o !== e_rd0 || c1_rdata_o !== e_rd1) begin
                failures++;
                $display("[TB] FAIL rand_rdata[%0d]: got %h/%h required %h/%h", cyc, c0_rdata_o, c1_rdata_o, e_rd0, e_rd1);
            end
            @(posedge clk);
            model_commit();
            if (e_g0) p0 = 1'b0;
            if (e_g1) p1 = 1'b0;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst_ni = 1'b1;
        clear_inputs();
        test_reset();
        test_single_core();
        test_round_robin();
        test_full();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
